// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, EX operand forwarding
// and saturating stall/flush event counters, tracked through EX/MEM/WB shadow registers.
module hazard_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1d,
    input  logic [ADDR_W-1:0] rs2d,
    input  logic [ADDR_W-1:0] rdd,
    input  logic              regwrited,
    input  logic              isloadd,
    input  logic              pcsrce,
    output logic              stallf,
    output logic              stalld,
    output logic              flushd,
    output logic              flushe,
    output logic [1:0]        forwardae,
    output logic [1:0]        forwardbe,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [ADDR_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic              ex_rw_q, ex_ld_q;
    logic [ADDR_W-1:0] ex_rs1_d, ex_rs2_d, ex_rd_d;
    logic              ex_rw_d, ex_ld_d;
    logic [ADDR_W-1:0] mem_rd_q, wb_rd_q;
    logic              mem_rw_q, wb_rw_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              lwstall;
    logic [1:0]        fwd_a, fwd_b;

    always_comb begin
        lwstall = ex_ld_q && (ex_rd_q != '0) && ((ex_rd_q == rs1d) || (ex_rd_q == rs2d));
    end

    // MEM result is younger than WB, so it is checked first; x0 never forwards.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_rw_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q)) begin
            fwd_a = 2'b10;
        end else if (wb_rw_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q)) begin
            fwd_a = 2'b01;
        end
        fwd_b = 2'b00;
        if (mem_rw_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q)) begin
            fwd_b = 2'b10;
        end else if (wb_rw_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q)) begin
            fwd_b = 2'b01;
        end
    end

    // A taken branch overrides a load-use stall: the stalled instruction is squashed anyway.
    always_comb begin
        stallf    = 1'b0;
        stalld    = 1'b0;
        flushd    = 1'b1;
        flushe    = 1'b1;
        forwardae = 2'b00;
        forwardbe = 2'b00;
        if (!reset) begin
            stallf    = lwstall && !pcsrce;
            stalld    = lwstall && !pcsrce;
            flushd    = pcsrce;
            flushe    = lwstall || pcsrce;
            forwardae = fwd_a;
            forwardbe = fwd_b;
        end
    end

    always_comb begin
        ex_rs1_d = rs1d;
        ex_rs2_d = rs2d;
        ex_rd_d  = rdd;
        ex_rw_d  = regwrited;
        ex_ld_d  = isloadd;
        if (flushe) begin
            ex_rs1_d = '0;
            ex_rs2_d = '0;
            ex_rd_d  = '0;
            ex_rw_d  = 1'b0;
            ex_ld_d  = 1'b0;
        end
        stall_cnt_d = stall_cnt_q;
        if (stallf && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (pcsrce && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_rd_q     <= mem_rd_q;
            wb_rw_q     <= mem_rw_q;
            mem_rd_q    <= ex_rd_q;
            mem_rw_q    <= ex_rw_q;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_ld_q     <= ex_ld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against an instruction-level pipeline model; a second instance checks 4-bit counter saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs1d = '0, rs2d = '0, rdd = '0;
    logic       regwrited = 1'b0, isloadd = 1'b0, pcsrce = 1'b0;

    logic        stallf, stalld, flushd, flushe;
    logic [1:0]  forwardae, forwardbe;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s4_stallf, s4_stalld, s4_flushd, s4_flushe;
    logic [1:0]  s4_fa, s4_fb;
    logic [3:0]  s4_stall_cnt, s4_flush_cnt;

    int tests = 0;
    int fails = 0;

    hazard_ctrl #(.ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .rs1d(rs1d), .rs2d(rs2d), .rdd(rdd),
        .regwrited(regwrited), .isloadd(isloadd), .pcsrce(pcsrce),
        .stallf(stallf), .stalld(stalld), .flushd(flushd), .flushe(flushe),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.ADDR_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .rs1d(rs1d), .rs2d(rs2d), .rdd(rdd),
        .regwrited(regwrited), .isloadd(isloadd), .pcsrce(pcsrce),
        .stallf(s4_stallf), .stalld(s4_stalld), .flushd(s4_flushd), .flushe(s4_flushe),
        .forwardae(s4_fa), .forwardbe(s4_fb),
        .stall_cnt(s4_stall_cnt), .flush_cnt(s4_flush_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one instruction record per stage, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        logic [4:0] rs1, rs2, rd;
        bit         rw, ld;
    } instr_t;

    instr_t pipe[3];
    int     m_stalls = 0;
    int     m_flushes = 0;

    function automatic instr_t bubble();
        instr_t b;
        b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.rw = 1'b0; b.ld = 1'b0;
        return b;
    endfunction

    function automatic bit exp_lw();
        if (reset) return 1'b0;
        return pipe[0].ld && pipe[0].rd != 0 && (pipe[0].rd == rs1d || pipe[0].rd == rs2d);
    endfunction

    function automatic bit exp_stall();
        return exp_lw() && !pcsrce;
    endfunction

    function automatic bit exp_flushe();
        return reset || exp_lw() || pcsrce;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (reset) return 2'b00;
        for (int s = 1; s <= 2; s++) begin
            if (pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == src)
                return (s == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic int sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    // Advance one clock; the model moves using the inputs that were present at the edge.
    task automatic tick();
        bit     st, fe;
        instr_t id;
        st = exp_stall();
        fe = exp_flushe();
        id.rs1 = rs1d; id.rs2 = rs2d; id.rd = rdd; id.rw = regwrited; id.ld = isloadd;
        @(posedge clk);
        if (reset) begin
            for (int s = 0; s < 3; s++) pipe[s] = bubble();
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            if (st) m_stalls++;
            if (pcsrce) m_flushes++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = fe ? bubble() : id;
        end
        #2;
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic w, input logic l, input logic p);
        rs1d = a; rs2d = b; rdd = d; regwrited = w; isloadd = l; pcsrce = p;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tests++;
            if ({stallf, stalld, flushd, flushe, forwardae, forwardbe} !== 8'b0011_0000) begin
                fails++;
                $display("FAIL reset_ctrl: got %b required 00110000",
                         {stallf, stalld, flushd, flushe, forwardae, forwardbe});
            end
            tick();
            tests++;
            if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
                fails++;
                $display("FAIL reset_cnt: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
            end
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if ({stallf, stalld, flushd, flushe, forwardae, forwardbe} !== 8'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got %b required 00000000",
                     {stallf, stalld, flushd, flushe, forwardae, forwardbe});
        end
        tick();
    endtask

    task automatic test_load_use();
        int base;
        base = m_stalls;
        drive(0, 0, 5, 1, 1, 0);
        tests++;
        if (stallf !== 1'b0) begin
            fails++; $display("FAIL lu_before: stallf got %b required 0", stallf);
        end
        tick();
        drive(5, 0, 6, 1, 0, 0);
        tests++;
        if ({stallf, stalld, flushd, flushe} !== 4'b1101) begin
            fails++; $display("FAIL lu_stall: got %b required 1101", {stallf, stalld, flushd, flushe});
        end
        tick();
        tests++;
        if ({stallf, flushe} !== 2'b00 || stall_cnt !== 16'(base + 1)) begin
            fails++;
            $display("FAIL lu_release: stall/flushe %b cnt %0d required 00 cnt %0d",
                     {stallf, flushe}, stall_cnt, base + 1);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if (forwardae !== 2'b01) begin
            fails++; $display("FAIL lu_fwd_wb: forwardae got %b required 01", forwardae);
        end
        tick();
    endtask

    task automatic test_alu_forward();
        drive(1, 2, 3, 1, 0, 0);
        tick();
        drive(3, 3, 4, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if ({forwardae, forwardbe} !== 4'b1010) begin
            fails++; $display("FAIL alu_fwd_mem: got %b required 1010", {forwardae, forwardbe});
        end
        drive(1, 2, 3, 1, 0, 0);
        tick();
        drive(1, 2, 9, 1, 0, 0);
        tick();
        drive(3, 3, 4, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if ({forwardae, forwardbe} !== 4'b0101) begin
            fails++; $display("FAIL alu_fwd_wb: got %b required 0101", {forwardae, forwardbe});
        end
        tick();
    endtask

    task automatic test_priority_x0();
        drive(0, 0, 7, 1, 0, 0); tick();
        drive(0, 0, 7, 1, 0, 0); tick();
        drive(7, 1, 2, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if (forwardae !== 2'b10) begin
            fails++; $display("FAIL fwd_priority: forwardae got %b required 10", forwardae);
        end
        drive(0, 0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0); tick();
        drive(0, 0, 2, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if ({forwardae, forwardbe} !== 4'b0000) begin
            fails++; $display("FAIL fwd_x0: got %b required 0000", {forwardae, forwardbe});
        end
        drive(0, 0, 0, 1, 1, 0); tick();
        drive(0, 0, 4, 1, 0, 0);
        tests++;
        if ({stallf, flushe} !== 2'b00) begin
            fails++; $display("FAIL load_x0_stall: got %b required 00", {stallf, flushe});
        end
        tick();
    endtask

    task automatic test_branch_vs_load();
        int s0, f0;
        drive(0, 0, 8, 1, 1, 0); tick();
        s0 = m_stalls; f0 = m_flushes;
        drive(1, 8, 9, 1, 0, 1);
        tests++;
        if ({stallf, stalld, flushd, flushe} !== 4'b0011) begin
            fails++; $display("FAIL branch_wins: got %b required 0011", {stallf, stalld, flushd, flushe});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if (flush_cnt !== 16'(f0 + 1) || stall_cnt !== 16'(s0)) begin
            fails++;
            $display("FAIL branch_cnt: flush %0d stall %0d required %0d %0d",
                     flush_cnt, stall_cnt, f0 + 1, s0);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [4:0] r;
        reset = 1'b1; drive(0, 0, 0, 0, 0, 0); tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            r = 5'($urandom_range(1, 31));
            drive(0, 0, r, 1, 1, 0); tick();
            drive(0, r, 1, 1, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if (s4_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
            fails++;
            $display("FAIL stall_saturate: cnt4 %0d cnt16 %0d required 15 20", s4_stall_cnt, stall_cnt);
        end
        drive(0, 0, 12, 1, 1, 0); tick();
        reset = 1'b1;
        drive(12, 0, 1, 1, 0, 0);
        tests++;
        if ({stallf, stalld} !== 2'b00) begin
            fails++; $display("FAIL reset_mid_stall: got %b required 00", {stallf, stalld});
        end
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (s4_stall_cnt !== 4'd0 || stall_cnt !== 16'd0 || stallf !== 1'b0) begin
            fails++;
            $display("FAIL sat_reset: cnt4 %0d cnt16 %0d stallf %b required 0 0 0",
                     s4_stall_cnt, stall_cnt, stallf);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            tests++;
            if (stallf !== exp_stall() || stalld !== exp_stall() ||
                flushd !== (reset || pcsrce) || flushe !== exp_flushe() ||
                forwardae !== exp_fwd(pipe[0].rs1) || forwardbe !== exp_fwd(pipe[0].rs2) ||
                stall_cnt !== 16'(sat(m_stalls, 16)) || flush_cnt !== 16'(sat(m_flushes, 16)) ||
                s4_stall_cnt !== 4'(sat(m_stalls, 4)) || s4_flush_cnt !== 4'(sat(m_flushes, 4))) begin
                fails++;
                $display("FAIL random[%0d]: got st%b%b fd%b fe%b fa%b fb%b c%0d/%0d c4 %0d/%0d required st%b fd%b fe%b fa%b fb%b c%0d/%0d c4 %0d/%0d",
                         i, stallf, stalld, flushd, flushe, forwardae, forwardbe, stall_cnt, flush_cnt,
                         s4_stall_cnt, s4_flush_cnt, exp_stall(), reset || pcsrce, exp_flushe(),
                         exp_fwd(pipe[0].rs1), exp_fwd(pipe[0].rs2), sat(m_stalls, 16),
                         sat(m_flushes, 16), sat(m_stalls, 4), sat(m_flushes, 4));
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) pipe[s] = bubble();
        test_reset();
        test_load_use();
        test_alu_forward();
        test_priority_x0();
        test_branch_vs_load();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control block that produces the stall, flush and forwarding controls consumed by the IF/ID and ID/EX pipeline registers. Its `flushe` output drives the ID/EX `clear` input. It keeps registered shadow copies of the register addresses and write-enables for the EX, MEM and WB stages. From these it resolves load-use stalls, branch flushes and EX-stage operand forwarding. It also keeps saturating stall and flush event counters for performance analysis.

Parameters:
- ADDR_W, 5, register-file address width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rs1d  input  ADDR_W  source register 1 of the instruction in ID.
- rs2d  input  ADDR_W  source register 2 of the instruction in ID.
- rdd  input  ADDR_W  destination register of the instruction in ID.
- regwrited  input  1  instruction in ID writes the register file.
- isloadd  input  1  instruction in ID is a load (result comes from memory).
- pcsrce  input  1  taken branch/jump resolved in EX this cycle.
- stallf  output  1  hold PC.
- stalld  output  1  hold the IF/ID register.
- flushd  output  1  clear the IF/ID register.
- flushe  output  1  clear the ID/EX register (drives its `clear`).
- forwardae  output  2  EX operand A select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- forwardbe  output  2  EX operand B select, same encoding as `forwardae`.
- stall_cnt  output  CNT_W  number of load-use stall cycles.
- flush_cnt  output  CNT_W  number of branch flush cycles.

Behaviour:
- Shadow state, all registers:
  - EX: `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_rw`, `ex_ld`.
  - MEM: `mem_rd`, `mem_rw`.
  - WB: `wb_rd`, `wb_rw`.
- Every clock, when not in reset:
  - WB shadow <= MEM shadow.
  - MEM shadow <= EX shadow.
  - EX shadow <= all zeros if `flushe` = 1; otherwise EX shadow <= ID inputs (`rs1d`, `rs2d`, `rdd`, `regwrited`, `isloadd`).
- Load-use detection is combinational from the EX shadow and the ID inputs:
  - `lwstall` = `ex_ld` & (`ex_rd` != 0) & (`ex_rd` == `rs1d` | `ex_rd` == `rs2d`).
- Control outputs (combinational):
  - `stallf` = `stalld` = `lwstall` & ~`pcsrce`.
  - `flushd` = `pcsrce`.
  - `flushe` = `lwstall` | `pcsrce`.
- Simultaneous `lwstall` and `pcsrce`: the flush wins.
  - Stalls deasserted, both flushes asserted.
  - Only `flush_cnt` increments.
- Forwarding for operand A:
  - `forwardae` = 10 if `mem_rw` & `mem_rd` != 0 & `mem_rd` == `ex_rs1`.
  - Else 01 if `wb_rw` & `wb_rd` != 0 & `wb_rd` == `ex_rs1`.
  - Else 00.
  - MEM has priority over WB.
- `forwardbe` uses the same rule against `ex_rs2`.
- Register x0 never forwards and never stalls.
- Counters:
  - `stall_cnt` increments in each cycle where `stallf` = 1.
  - `flush_cnt` increments in each cycle where `pcsrce` = 1.
  - Both saturate at all-ones; no wrap.
- Reset:
  - While `reset` = 1: all shadow registers and counters clear to 0 at the clock edge.
  - Outputs forced during reset: `stallf` = `stalld` = 0, `flushd` = `flushe` = 1, `forwardae` = `forwardbe` = 00.
  - Reset asserted mid-stall drops the stall on the same cycle; the pending load is discarded.
- First cycle after reset deasserts: all outputs are 0 unless `pcsrce` = 1.
- Latency:
  - Stall and flush respond in the same cycle as their inputs.
  - Forwarding reflects shadow state registered on the previous edge.
  - Counters update one cycle after the event.

Test Plan:
- Reset held 3 cycles with random inputs -> `flushd` = `flushe` = 1, `stallf` = 0, forwards 00, counters 0; after release with idle inputs all controls are 0.
- Load x5 in ID, then next cycle `rs1d` = 5 -> `stallf` = `stalld` = `flushe` = 1 for exactly 1 cycle, `stall_cnt` = 1. Next cycle the EX shadow is a bubble. Two cycles later the load is in WB and `forwardae` = 01.
- ALU op writes x3, followed by op reading `rs1` = 3, `rs2` = 3 -> `forwardae` = `forwardbe` = 10 one cycle later. With one unrelated instruction between them -> 01.
- MEM and WB both write x7, EX reads x7 -> `forwardae` = 10 (MEM priority). Same sequence targeting x0 -> 00, and a load to x0 gives no stall.
- `pcsrce` = 1 for one cycle while a load-use is detected -> `stallf` = 0, `flushd` = `flushe` = 1, `flush_cnt` += 1, `stall_cnt` unchanged.
- With CNT_W = 4, drive 20 load-use stalls -> `stall_cnt` saturates at 15. Reset -> `stall_cnt` = 0.
